mem_uploader: RTL and testbench



---
 rtl/mem_uploader.sv | 189 ++++++++++++++++++
 tb/tb_mem_uploader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_uploader.sv
// Reads bytes back out of SDRAM for HPS upload (save) requests, using the same
// address map as the ROM/expansion download path so an image reads back byte-exactly.
module mem_uploader #(
    parameter int          ADDR_W   = 25,
    parameter logic [7:0]  OOR_BYTE = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce_ref,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_index,
    input  logic [31:0]       ioctl_file_ext,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              upload_active,
    output logic              mem_rd,
    output logic [22:0]       mem_a,
    output logic [1:0]        mem_bank,
    input  logic [7:0]        mem_dout
);

    localparam int AW_EXT = (ADDR_W > 25) ? ADDR_W : 25;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_READ, ST_DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  din_reg, din_next;
    logic        wait_reg, wait_next;
    logic        mem_rd_reg, mem_rd_next;
    logic [22:0] mem_a_reg, mem_a_next;
    logic [1:0]  mem_bank_reg, mem_bank_next;
    logic        active_reg, active_next;
    logic [8:0]  page_reg, page_next;
    logic        oor_hold_reg, oor_hold_next;

    logic [7:0]  ext_char [2];
    logic        ext_hex  [2];
    logic [3:0]  ext_val  [2];
    logic [8:0]  page_new;
    logic [8:0]  page_eff;
    logic        upload_rise;

    logic [AW_EXT-1:0] addr_ext;
    logic [8:0]        boot_hi;
    logic [22:0]       map_a;
    logic [1:0]        map_bank;
    logic              map_oor;

    logic unused_ext;
    assign unused_ext = ^ioctl_file_ext[31:16];

    // Decode the last two extension characters as hex digits ('0'-'9', 'A'-'F').
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ext
            assign ext_char[gi] = ioctl_file_ext[8*gi +: 8];
            assign ext_hex[gi]  = ((ext_char[gi] >= 8'h30) && (ext_char[gi] <= 8'h39)) ||
                                  ((ext_char[gi] >= 8'h41) && (ext_char[gi] <= 8'h46));
            assign ext_val[gi]  = (ext_char[gi] <= 8'h39) ? ext_char[gi][3:0]
                                                          : ext_char[gi][3:0] + 4'd9;
        end
    endgenerate

    // Any hex override clears bit 8: only the untouched 9'h1EE default keeps it.
    always_comb begin
        page_new = (ioctl_index != 8'd0) ? 9'h1EE : 9'h000;
        if (ext_hex[1]) page_new = {1'b0, ext_val[1], page_new[3:0]};
        if (ext_hex[0]) page_new = {1'b0, page_new[7:4], ext_val[0]};
        if ((ext_char[1] == 8'h5A) && ((ext_char[0] == 8'h5A) || (ext_char[0] == 8'h30)))
            page_new = 9'h000;
    end

    assign upload_rise = ioctl_upload & ~active_reg;
    assign page_eff    = upload_rise ? page_new : page_reg;
    assign addr_ext    = AW_EXT'(ioctl_addr);

    always_comb begin
        map_oor  = 1'b0;
        map_bank = 2'd0;
        map_a    = 23'd0;
        boot_hi  = 9'h000;
        if (ioctl_index != 8'd0) begin
            map_a    = {page_eff[8], page_eff[7:0] + addr_ext[21:14], addr_ext[13:0]};
            map_bank = {1'b0, &ioctl_index[7:6]};
        end else begin
            case (addr_ext[15:14])
                2'd0:    boot_hi = 9'h000;
                2'd1:    boot_hi = 9'h100;
                2'd2:    boot_hi = 9'h107;
                default: boot_hi = 9'h1FF;
            endcase
            map_a    = {boot_hi, addr_ext[13:0]};
            map_bank = {1'b0, addr_ext[16]};
            map_oor  = |addr_ext[AW_EXT-1:17];
        end
    end

    always_comb begin
        state_next    = state_reg;
        din_next      = din_reg;
        wait_next     = wait_reg;
        mem_rd_next   = mem_rd_reg;
        mem_a_next    = mem_a_reg;
        mem_bank_next = mem_bank_reg;
        oor_hold_next = 1'b0;
        active_next   = ioctl_upload;
        page_next     = upload_rise ? page_new : page_reg;

        case (state_reg)
            ST_IDLE: begin
                if (ioctl_rd && ioctl_upload) begin
                    wait_next = 1'b1;
                    if (map_oor) begin
                        din_next      = OOR_BYTE;
                        oor_hold_next = 1'b1;
                        state_next    = ST_DONE;
                    end else begin
                        mem_a_next    = map_a;
                        mem_bank_next = map_bank;
                        state_next    = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (!ioctl_upload) begin
                    wait_next   = 1'b0;
                    mem_rd_next = 1'b0;
                    state_next  = ST_IDLE;
                end else if (ce_ref) begin
                    mem_rd_next = 1'b1;
                    state_next  = ST_READ;
                end
            end
            ST_READ: begin
                if (!ioctl_upload) begin
                    wait_next   = 1'b0;
                    mem_rd_next = 1'b0;
                    state_next  = ST_IDLE;
                end else if (ce_ref) begin
                    din_next    = mem_dout;
                    mem_rd_next = 1'b0;
                    state_next  = ST_DONE;
                end
            end
            default: begin
                // Out-of-range replies spend one extra cycle here so wait spans two cycles.
                if (oor_hold_reg) begin
                    oor_hold_next = 1'b0;
                end else begin
                    wait_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            din_reg      <= 8'd0;
            wait_reg     <= 1'b0;
            mem_rd_reg   <= 1'b0;
            mem_a_reg    <= 23'd0;
            mem_bank_reg <= 2'd0;
            active_reg   <= 1'b0;
            page_reg     <= 9'd0;
            oor_hold_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            din_reg      <= din_next;
            wait_reg     <= wait_next;
            mem_rd_reg   <= mem_rd_next;
            mem_a_reg    <= mem_a_next;
            mem_bank_reg <= mem_bank_next;
            active_reg   <= active_next;
            page_reg     <= page_next;
            oor_hold_reg <= oor_hold_next;
        end
    end

    assign ioctl_din     = din_reg;
    assign ioctl_wait    = wait_reg;
    assign mem_rd        = mem_rd_reg;
    assign mem_a         = mem_a_reg;
    assign mem_bank      = mem_bank_reg;
    assign upload_active = active_reg;

endmodule

// File: tb/tb_mem_uploader.sv
// Self-checking bench for mem_uploader: directed boundary cases plus randomized
// upload sessions compared against a behavioural page/address-map and SDRAM model.
module tb_mem_uploader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_ref = 1'b0;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_index;
    logic [31:0] ioctl_file_ext;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        upload_active;
    logic        mem_rd;
    logic [22:0] mem_a;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_dout;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [8:0]  m_page = 9'd0;
    logic [7:0]  last_din = 8'd0;
    logic [3:0]  ce_cnt = 4'd0;

    typedef struct packed {
        logic        oor;
        logic [1:0]  bank;
        logic [22:0] a;
    } map_t;

    mem_uploader #(.ADDR_W(25), .OOR_BYTE(8'hFF)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_index(ioctl_index), .ioctl_file_ext(ioctl_file_ext),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .upload_active(upload_active),
        .mem_rd(mem_rd), .mem_a(mem_a), .mem_bank(mem_bank), .mem_dout(mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        ce_cnt = ce_cnt + 4'd1;
        ce_ref = (ce_cnt == 4'd0);
    end

    function automatic logic [7:0] sdram_byte(input logic [1:0] b, input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ {a[3:0], a[11:8]} ^ {b, 6'h15};
    endfunction

    assign mem_dout = sdram_byte(mem_bank, mem_a);

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
    endfunction

    function automatic logic [3:0] hex_of(input logic [7:0] c);
        int v;
        v = (c <= "9") ? int'(c) - int'("0") : int'(c) - int'("A") + 10;
        return 4'(v);
    endfunction

    function automatic logic [8:0] model_page(input logic [7:0] idx, input logic [31:0] ext);
        logic [7:0] hi, lo;
        int p;
        hi = ext[15:8];
        lo = ext[7:0];
        if (hi == "Z" && (lo == "Z" || lo == "0")) return 9'd0;
        p = (idx != 0) ? 'h1EE : 0;
        if (is_hex(hi)) p = (p % 16) + 16 * int'(hex_of(hi));
        if (is_hex(lo)) p = (p / 16 % 16) * 16 + int'(hex_of(lo));
        return 9'(p);
    endfunction

    function automatic map_t model_map(input logic [7:0] idx, input logic [24:0] addr,
                                       input logic [8:0] page);
        map_t m;
        int seg, hi;
        int boot_base [4] = '{'h000, 'h100, 'h107, 'h1FF};
        m = '0;
        if (idx != 0) begin
            hi = int'(page[8]) * 256 + ((int'(page[7:0]) + int'(addr[21:14])) % 256);
            m.a = 23'(hi * 16384 + int'(addr[13:0]));
            m.bank = (idx >= 8'hC0) ? 2'd1 : 2'd0;
        end else begin
            seg = int'(addr) / 16384;
            if (seg >= 8) begin
                m.oor = 1'b1;
            end else begin
                m.a = 23'(boot_base[seg % 4] * 16384 + int'(addr[13:0]));
                m.bank = (seg >= 4) ? 2'd1 : 2'd0;
            end
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".din"},    32'(ioctl_din), 32'h0);
        chk({tag, ".wait"},   32'(ioctl_wait), 32'h0);
        chk({tag, ".mem_rd"}, 32'(mem_rd), 32'h0);
        chk({tag, ".mem_a"},  32'(mem_a), 32'h0);
        chk({tag, ".bank"},   32'(mem_bank), 32'h0);
        chk({tag, ".active"}, 32'(upload_active), 32'h0);
    endtask

    // One request/response; rise=1 raises ioctl_upload in the same cycle as the request.
    task automatic do_read(input logic [24:0] addr, input bit rise, input bit poke, input string tag);
        map_t m;
        logic [7:0] ed;
        int wc, rc, bad_a, extra;
        if (rise) m_page = model_page(ioctl_index, ioctl_file_ext);
        m = model_map(ioctl_index, addr, m_page);
        ed = m.oor ? 8'hFF : sdram_byte(m.bank, m.a);
        @(negedge clk_sys);
        ioctl_addr = addr;
        ioctl_rd = 1'b1;
        if (rise) ioctl_upload = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        chk({tag, ".wait_rise"}, 32'(ioctl_wait), 32'h1);
        wc = 0; rc = 0; bad_a = 0;
        while (ioctl_wait && wc < 64) begin
            wc++;
            if (mem_rd) rc++;
            if (!m.oor && (mem_a !== m.a || mem_bank !== m.bank)) bad_a++;
            ioctl_rd = poke && (rc == 5);
            @(negedge clk_sys);
        end
        ioctl_rd = 1'b0;
        if (m.oor) chk({tag, ".wait_len"}, 32'(wc), 32'd2);
        else       chk({tag, ".wait_len_in_18_33"}, 32'(wc >= 18 && wc <= 33), 32'h1);
        chk({tag, ".rd_len"}, 32'(rc), m.oor ? 32'd0 : 32'd16);
        chk({tag, ".din"}, 32'(ioctl_din), 32'(ed));
        if (!m.oor) begin
            chk({tag, ".mem_a"}, 32'(mem_a), 32'(m.a));
            chk({tag, ".bank"}, 32'(mem_bank), 32'(m.bank));
            chk({tag, ".addr_stable"}, 32'(bad_a), 32'd0);
        end
        if (poke) begin
            extra = 0;
            repeat (4) begin
                @(negedge clk_sys);
                if (ioctl_wait || mem_rd) extra++;
            end
            chk({tag, ".no_queue"}, 32'(extra), 32'd0);
        end
        last_din = ed;
        $display("txn %s idx=%02h addr=%07h page=%03h din=%02h wait=%0d rd=%0d", tag,
                 ioctl_index, addr, m_page, ioctl_din, wc, rc);
    endtask

    task automatic close_session();
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic set_file(input logic [7:0] idx, input logic [7:0] c_hi, input logic [7:0] c_lo);
        ioctl_index = idx;
        ioctl_file_ext = {16'h2E52, c_hi, c_lo};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        string charset;
        int n, gap, cyc;
        logic [24:0] a;
        charset = "0123456789ABCDEFZGa";
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
        ioctl_index = 8'd0; ioctl_file_ext = 32'd0;
        repeat (3) @(negedge clk_sys);
        chk_reset_vals("reset");
        reset = 1'b0;

        // request with upload low is ignored
        @(negedge clk_sys); ioctl_rd = 1'b1;
        @(negedge clk_sys); ioctl_rd = 1'b0;
        chk("rd_no_upload.wait", 32'(ioctl_wait), 32'h0);

        // boot ROM map
        set_file(8'h00, "R", "M");
        do_read(25'h04005, 1'b1, 1'b0, "boot_seg1");
        chk("upload_active", 32'(upload_active), 32'h1);
        do_read(25'h1C123, 1'b0, 1'b0, "boot_seg7");
        do_read(25'h0BFFF, 1'b0, 1'b0, "boot_seg2");
        do_read(25'h20000, 1'b0, 1'b0, "boot_oor");
        close_session();

        // page from extension, request in the rise cycle
        set_file(8'h01, "1", "F");
        do_read(25'h0C000, 1'b1, 1'b0, "page_1F");
        ioctl_index = 8'hC1;
        do_read(25'h0C000, 1'b0, 1'b0, "page_1F_bank1");
        close_session();

        set_file(8'h01, "Z", "Z");
        do_read(25'h3FC000, 1'b1, 1'b0, "zz_top");
        do_read(25'h400000, 1'b0, 1'b0, "zz_wrap");
        close_session();

        set_file(8'h02, "O", "M");
        do_read(25'h0123A, 1'b1, 1'b0, "default_1EE");
        close_session();

        // second request during READ is dropped
        set_file(8'h00, "Z", "0");
        do_read(25'h08010, 1'b1, 1'b1, "poke_read");

        // upload drop while READ aborts
        @(negedge clk_sys); ioctl_addr = 25'h04444; ioctl_rd = 1'b1;
        @(negedge clk_sys); ioctl_rd = 1'b0;
        cyc = 0;
        while (!mem_rd && cyc < 40) begin @(negedge clk_sys); cyc++; end
        chk("abort.reached_read", 32'(mem_rd), 32'h1);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        chk("abort.wait", 32'(ioctl_wait), 32'h0);
        chk("abort.mem_rd", 32'(mem_rd), 32'h0);
        chk("abort.din_held", 32'(ioctl_din), 32'(last_din));
        $display("txn abort_in_read din=%02h", ioctl_din);
        repeat (2) @(negedge clk_sys);

        // reset while ARM, then a normal request
        set_file(8'h05, "3", "G");
        do_read(25'h00100, 1'b1, 1'b0, "pre_reset");
        @(negedge clk_sys); ioctl_addr = 25'h00200; ioctl_rd = 1'b1;
        @(negedge clk_sys); ioctl_rd = 1'b0; reset = 1'b1;
        @(negedge clk_sys); reset = 1'b0;
        chk_reset_vals("reset_arm");
        $display("txn reset_in_arm");
        last_din = 8'd0;
        do_read(25'h00300, 1'b0, 1'b0, "post_reset");
        close_session();

        // randomized sessions
        for (int s = 0; s < 10; s++) begin
            set_file((($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom)),
                     charset[$urandom_range(0, charset.len() - 1)],
                     charset[$urandom_range(0, charset.len() - 1)]);
            n = $urandom_range(3, 6);
            for (int r = 0; r < n; r++) begin
                if (ioctl_index == 8'h00)
                    a = {11'($urandom_range(0, 9)), 14'($urandom)};
                else
                    a = 25'($urandom);
                gap = $urandom_range(0, 20);
                repeat (gap) @(negedge clk_sys);
                do_read(a, (r == 0), 1'b0, $sformatf("rnd%0d_%0d", s, r));
            end
            close_session();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
